// File: rtl/jtvigil_prom_we.sv
// ROM download writer: converts the ioctl byte stream into SDRAM
// programming writes. It maps the flat image into banks 0-3 and swizzles
// object-ROM addresses so that one 32-bit fetch returns a full sprite row.
// A one-entry buffer absorbs a byte that arrives while a write is in flight.
module jtvigil_prom_we #(
   parameter logic [24:0] BA1_START = 25'h2_0000,
   parameter logic [24:0] BA2_START = 25'h4_0000,
   parameter logic [24:0] BA3_START = 25'h9_0000,
   parameter logic [24:0] ROM_END   = 25'hD_0000,
   parameter int          POST_CYC  = 8
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        downloading_i,
   input  logic [24:0] ioctl_addr_i,
   input  logic [7:0]  ioctl_dout_i,
   input  logic        ioctl_wr_i,
   output logic [21:0] prog_addr_o,
   output logic [15:0] prog_data_o,
   output logic [1:0]  prog_mask_o,
   output logic [1:0]  prog_ba_o,
   output logic        prog_we_o,
   output logic        prog_rd_o,
   input  logic        prog_ack_i,
   input  logic        prog_rdy_i,
   output logic        dwnld_busy_o,
   output logic        overrun_o
);

   // The image ends below 2^23, so an accepted address always fits in 23 bits.
   localparam logic [22:0] B1 = BA1_START[22:0];
   localparam logic [22:0] B2 = BA2_START[22:0];
   localparam logic [22:0] B3 = BA3_START[22:0];
   localparam int          PW = $clog2(POST_CYC + 1);
   localparam logic [PW-1:0] POST_LD = PW'(POST_CYC);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t        state_q, state_d;
   logic          buf_vld_q;
   logic [22:0]   buf_addr_q;
   logic [7:0]    buf_data_q;
   logic          overrun_q;
   logic [PW-1:0] post_q;

   logic        accept, pop, rdy_evt;
   logic [22:0] off;
   logic [21:0] w, addr_map;
   logic [1:0]  ba_map, mask_map;

   assign accept  = ioctl_wr_i & downloading_i & (ioctl_addr_i < ROM_END);
   assign pop     = (state_q == IDLE) & buf_vld_q;
   assign rdy_evt = prog_rdy_i & ((state_q == WAIT) | ((state_q == REQ) & prog_ack_i));

   // Bank select and in-bank word address for the buffered byte
   always_comb begin
      ba_map = 2'd0;
      off    = buf_addr_q;
      if (buf_addr_q < B1) begin
         ba_map = 2'd0;
         off    = buf_addr_q;
      end else if (buf_addr_q < B2) begin
         ba_map = 2'd1;
         off    = buf_addr_q - B1;
      end else if (buf_addr_q < B3) begin
         ba_map = 2'd2;
         off    = buf_addr_q - B2;
      end else begin
         ba_map = 2'd3;
         off    = buf_addr_q - B3;
      end
      w        = off[22:1];
      // Object ROM: word bit 4 moves to bit 0 so a sprite row is contiguous
      addr_map = (ba_map == 2'd3) ? {w[21:5], w[3:0], w[4]} : w;
      mask_map = off[0] ? 2'b01 : 2'b10;
   end

   // Input buffer: a new byte may take the slot freed by a same-cycle pop
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         buf_vld_q  <= 1'b0;
         buf_addr_q <= '0;
         buf_data_q <= '0;
         overrun_q  <= 1'b0;
      end else begin
         if (accept && (!buf_vld_q || pop)) begin
            buf_vld_q  <= 1'b1;
            buf_addr_q <= ioctl_addr_i[22:0];
            buf_data_q <= ioctl_dout_i;
         end else begin
            if (pop) buf_vld_q <= 1'b0;
            if (accept) overrun_q <= 1'b1;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (buf_vld_q) state_d = REQ;
         REQ:  if (prog_ack_i) state_d = prog_rdy_i ? IDLE : WAIT;
         WAIT: if (prog_rdy_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: request is asserted for the whole REQ state
   always_comb begin
      prog_we_o = (state_q == REQ);
      prog_rd_o = 1'b0;
   end

   // Request payload, captured when the buffer is popped and held through REQ
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prog_addr_o <= '0;
         prog_data_o <= '0;
         prog_mask_o <= 2'b11;
         prog_ba_o   <= 2'd0;
      end else if (pop) begin
         prog_addr_o <= addr_map;
         prog_data_o <= {buf_data_q, buf_data_q};
         prog_mask_o <= mask_map;
         prog_ba_o   <= ba_map;
      end
   end

   // Tail counter keeps busy high for a few idle cycles after the last write
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) post_q <= '0;
      else if (rdy_evt) post_q <= POST_LD;
      else if (!downloading_i && state_q == IDLE && !buf_vld_q && post_q != '0)
         post_q <= post_q - 1'b1;
   end

   assign overrun_o    = overrun_q;
   assign dwnld_busy_o = downloading_i | (state_q != IDLE) | buf_vld_q | (post_q != '0);

endmodule
